// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    // Controller side: issues operations and collects results.
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
        input  borrow_out
    );

    // Subtractor side.
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
        output borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned a - b, LSB first, one full-subtractor cell
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_shift;
    logic             bin;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             done_q;

    logic             ai;
    logic             bi;
    logic             d;
    logic             bout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept start only when idle, leave RUN on the final bit.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs; the result bit enters from the top.
    always_comb begin
        ai      = a_sr[0];
        bi      = b_sr[0];
        d       = ai ^ bi ^ bin;
        bout    = (~ai & bi) | (~(ai ^ bi) & bin);
        r_shift = {d, r_sr[WIDTH-1:1]};
    end

    // Datapath: load on accept, shift one bit per RUN cycle, publish on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            bin      <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_sr <= bus.a;
                b_sr <= bus.b;
                r_sr <= '0;
                bin  <= 1'b0;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= r_shift;
                bin  <= bout;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    diff_q   <= r_shift;
                    borrow_q <= bout;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   done_cnt;
    int   exp_done;
    logic [WIDTH-1:0] last_diff;
    logic             last_borrow;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse seen, independent of the scenario code.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer subtraction, wrapped to WIDTH bits.
    function automatic logic [WIDTH:0] ref_sub(input int x, input int y);
        int r;
        logic br;
        r  = x - y;
        br = (r < 0);
        if (r < 0) r = r + (1 << WIDTH);
        return {br, r[WIDTH-1:0]};
    endfunction

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
    endtask

    // Runs from the accepting edge to the done cycle; optionally pokes start at cycle intr.
    task automatic finish_op(input logic [WIDTH-1:0] ed, input logic eb, input int intr, input string tag);
        int bad;
        bad = 0;
        tick();
        bus.start = 1'b0;
        bus.a     = $urandom_range(0, 255);
        bus.b     = $urandom_range(0, 255);
        for (int i = 1; i < WIDTH; i++) begin
            if (i == intr) issue(8'h00, 8'hFF);
            tick();
            bus.start = 1'b0;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                bus.diff !== last_diff || bus.borrow_out !== last_borrow) bad++;
        end
        check({tag, "_run"}, bad, 0);
        tick();
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_diff"}, bus.diff, ed);
        check({tag, "_borrow"}, bus.borrow_out, eb);
        last_diff   = ed;
        last_borrow = eb;
        exp_done++;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        check({tag, "_idle"}, bad, 0);
        check({tag, "_done_count"}, done_cnt, exp_done);
    endtask

    initial begin
        logic [WIDTH:0] m;
        logic [WIDTH-1:0] ra, rb;
        checks      = 0;
        failures    = 0;
        done_cnt    = 0;
        exp_done    = 0;
        last_diff   = '0;
        last_borrow = 1'b0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;

        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_borrow", bus.borrow_out, 0);

        // Start on the very first edge after reset release.
        rst_n = 1'b1;
        issue(8'h5A, 8'h23);
        finish_op(8'h37, 1'b0, 0, "basic");
        tick();
        check("basic_done_fall", bus.done, 0);
        idle_cycles(2, "basic");

        issue(8'h10, 8'h20);  finish_op(8'hF0, 1'b1, 0, "wrap1");  idle_cycles(1, "wrap1");
        issue(8'h00, 8'h01);  finish_op(8'hFF, 1'b1, 0, "wrap2");  idle_cycles(1, "wrap2");
        issue(8'hAA, 8'hAA);  finish_op(8'h00, 1'b0, 0, "equal");  idle_cycles(1, "equal");
        issue(8'hFF, 8'h00);  finish_op(8'hFF, 1'b0, 0, "max");    idle_cycles(1, "max");

        // start pulsed mid-run must be dropped, not queued.
        issue(8'h80, 8'h01);  finish_op(8'h7F, 1'b0, 3, "ignore");
        idle_cycles(WIDTH + 3, "ignore");

        // Back-to-back: second start presented in the done cycle.
        issue(8'h05, 8'h03);
        finish_op(8'h02, 1'b0, 0, "b2b1");
        issue(8'h03, 8'h05);
        finish_op(8'hFE, 1'b1, 0, "b2b2");
        idle_cycles(2, "b2b");

        // Asynchronous reset in the middle of a run.
        issue(8'h5A, 8'h23);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_diff", bus.diff, 0);
        check("midrst_borrow", bus.borrow_out, 0);
        last_diff   = '0;
        last_borrow = 1'b0;
        tick();
        rst_n = 1'b1;
        idle_cycles(WIDTH + 2, "midrst");
        issue(8'h09, 8'h04);
        finish_op(8'h05, 1'b0, 0, "after_rst");
        idle_cycles(1, "after_rst");

        // Random operations, sometimes chained back-to-back.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            m  = ref_sub(ra, rb);
            issue(ra, rb);
            finish_op(m[WIDTH-1:0], m[WIDTH], 0, "rand");
            if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(1, 3), "rand");
        end
        idle_cycles(2, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
